// File: rtl/add32_sched_pkg.sv
// add32_sched_pkg: shared types and constants for the add32_sched adder scheduler.
package add32_sched_pkg;
    localparam int WORD_W = 32;
    localparam int IDX_W = 3;
    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_e;
    typedef struct packed {
        logic              valid;
        logic [IDX_W-1:0]  idx;
        logic [WORD_W-1:0] a;
        logic [WORD_W-1:0] b;
    } entry_t;
endpackage

// File: rtl/add32_pipe.sv
// add32_pipe: LAT-stage tagged operand pipeline; the 33-bit add is formed on the final stage.
module add32_pipe
    import add32_sched_pkg::*;
#(
    parameter int LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  entry_t            in_i,
    output logic              valid_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic [WORD_W-1:0] sum_o,
    output logic              carry_o
);
    entry_t stg_q [LAT];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) stg_q[i] <= '0;
        end else begin
            stg_q[0] <= in_i;
            for (int i = 1; i < LAT; i++) stg_q[i] <= stg_q[i-1];
        end
    end
    assign {carry_o, sum_o} = {1'b0, stg_q[LAT-1].a} + {1'b0, stg_q[LAT-1].b};
    assign valid_o = stg_q[LAT-1].valid;
    assign idx_o = stg_q[LAT-1].idx;
endmodule

// File: rtl/add32_sched.sv
// add32_sched: shares one pipelined 32-bit adder among NREQ requesters with drain/flush control.
// ADD32_SCHED_FIXED_PRIO_EN selects lowest-index-wins arbitration instead of round-robin.
module add32_sched
    import add32_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [WORD_W*NREQ-1:0] req_a,
    input  logic [WORD_W*NREQ-1:0] req_b,
    output logic [NREQ-1:0]        req_ready,
    input  logic                   flush,
    output logic                   flush_done,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [WORD_W-1:0]      rsp_sum,
    output logic                   rsp_carry,
    output logic                   busy
);
    localparam int CW = $clog2(LAT + 1);
    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NREQ-1:0] gnt;
    logic [IDX_W-1:0] gidx;
    logic found, issue;
    int cand;
    entry_t pin;
    logic p_valid;
    logic [IDX_W-1:0] p_idx;
`ifndef ADD32_SCHED_FIXED_PRIO_EN
    localparam int IW = $clog2(NREQ);
    logic [IW-1:0] ptr_q;
    always_ff @(posedge clk) begin
        ptr_q <= rst ? '0 : issue ? IW'((int'(gidx) + 1) % NREQ) : ptr_q;
    end
`endif
    // Scan starts at the priority index; first valid requester wins.
    always_comb begin
        gnt = '0;
        gidx = '0;
        found = 1'b0;
        cand = 0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef ADD32_SCHED_FIXED_PRIO_EN
            cand = k;
`else
            cand = (int'(ptr_q) + k) % NREQ;
`endif
            if (!found && req_valid[cand]) begin
                gnt[cand] = 1'b1;
                gidx = IDX_W'(cand);
                found = 1'b1;
            end
        end
    end
    assign req_ready = (state_q == RUN && !rst) ? gnt : '0;
    assign issue = |req_ready;
    assign pin = '{valid: issue, idx: gidx,
                   a: req_a[WORD_W*gidx +: WORD_W], b: req_b[WORD_W*gidx +: WORD_W]};
    add32_pipe #(.LAT(LAT)) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_i    (pin),
        .valid_o (p_valid),
        .idx_o   (p_idx),
        .sum_o   (rsp_sum),
        .carry_o (rsp_carry)
    );
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) rsp_valid[i] = p_valid && (p_idx == IDX_W'(i));
    end
    // An op stays counted through its response cycle, so DRAIN looks at the next count.
    always_comb begin
        cnt_d = cnt_q + CW'(issue) - CW'(p_valid);
        state_d = (state_q == RUN) ? (flush ? DRAIN : RUN) :
                  (state_q == DRAIN) ? (!flush ? RUN : (cnt_d == '0) ? HALT : DRAIN) :
                  (flush ? HALT : RUN);
    end
    always_ff @(posedge clk) begin
        state_q <= rst ? RUN : state_d;
        cnt_q <= rst ? '0 : cnt_d;
    end
    assign busy = cnt_q != '0;
    assign flush_done = state_q == HALT;
endmodule
